thread_fetch_sched: RTL and testbench

- Fetch-side thread scheduler. It produces the pc_if / thread_if pair that the IF/ID pipeline register captures.
- It holds one program counter and one active bit for each of the 4 hardware threads, and issues them round-robin.
- It accepts branch redirects from the MEM stage and processing-done retirements from the ID/EX path.
- It advances only on the same en that enables the IF/ID register.

---
 rtl/thread_fetch_sched.sv | 137 +++++++++++++
 tb/tb_thread_fetch_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch_sched.sv
// Fetch-side round-robin scheduler for 4 hardware threads.
// Issues pc_if/thread_if for the IF/ID register. Accepts branch redirects
// and done retirements, and a synchronous restart.
// Ports:
//   clk, reset             : clock (rising edge), async active-low reset
//   en                     : fetch advance (same as IF/ID register enable)
//   pc_if, thread_if       : issued fetch PC and thread id
//   fetch_valid            : pc_if/thread_if hold a real fetch
//   redirect_valid/_thread/_pc : load a thread's PC with a branch target
//   done_valid/_thread     : deactivate a thread
//   restart                : re-arm all threads to their start PCs
//   thread_active, all_done: per-thread active bits, all threads retired
module thread_fetch_sched #(
    parameter int unsigned PC_W        = 9,
    parameter int unsigned PC_INC      = 1,
    parameter int unsigned THREAD_SPAN = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [PC_W-1:0] pc_if,
    output logic [1:0]      thread_if,
    output logic            fetch_valid,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_thread,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            done_valid,
    input  logic [1:0]      done_thread,
    input  logic            restart,
    output logic [3:0]      thread_active,
    output logic            all_done
);

    localparam int unsigned NT = 4;

    logic [PC_W-1:0] pc_q [NT];
    logic [PC_W-1:0] pc_d [NT];
    logic [3:0]      active_q, active_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [PC_W-1:0] pc_if_q, pc_if_d;
    logic [1:0]      thread_if_q, thread_if_d;
    logic            fetch_valid_q, fetch_valid_d;

    logic [3:0]      eff_active;
    logic [1:0]      sel;
    logic            none;

    // Round-robin pick starting at ptr; a thread retired this cycle is skipped.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx        = '0;
        found      = 1'b0;
        sel        = ptr_q;
        eff_active = active_q;
        if (done_valid) begin
            eff_active[done_thread] = 1'b0;
        end
        for (int i = 0; i < int'(NT); i++) begin
            idx = ptr_q + 2'(i);
            if (!found && eff_active[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        none = !found;
    end

    // Next state: issue, then redirect (overrides increment), then restart (overrides all).
    always_comb begin
        for (int i = 0; i < int'(NT); i++) begin
            pc_d[i] = pc_q[i];
        end
        active_d      = eff_active;
        ptr_d         = ptr_q;
        pc_if_d       = pc_if_q;
        thread_if_d   = thread_if_q;
        fetch_valid_d = fetch_valid_q;

        if (en) begin
            if (!none) begin
                pc_d[sel]     = pc_q[sel] + PC_W'(PC_INC);
                pc_if_d       = pc_q[sel];
                thread_if_d   = sel;
                fetch_valid_d = 1'b1;
                ptr_d         = sel + 2'd1;
            end else begin
                fetch_valid_d = 1'b0;
            end
        end

        if (redirect_valid) begin
            pc_d[redirect_thread] = redirect_pc;
        end

        if (restart) begin
            for (int i = 0; i < int'(NT); i++) begin
                pc_d[i] = PC_W'(i * int'(THREAD_SPAN));
            end
            active_d      = 4'b1111;
            ptr_d         = 2'd0;
            fetch_valid_d = 1'b0;
            pc_if_d       = pc_if_q;
            thread_if_d   = thread_if_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NT); i++) begin
                pc_q[i] <= PC_W'(i * int'(THREAD_SPAN));
            end
            active_q      <= 4'b1111;
            ptr_q         <= 2'd0;
            pc_if_q       <= '0;
            thread_if_q   <= 2'd0;
            fetch_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NT); i++) begin
                pc_q[i] <= pc_d[i];
            end
            active_q      <= active_d;
            ptr_q         <= ptr_d;
            pc_if_q       <= pc_if_d;
            thread_if_q   <= thread_if_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign pc_if         = pc_if_q;
    assign thread_if     = thread_if_q;
    assign fetch_valid   = fetch_valid_q;
    assign thread_active = active_q;
    assign all_done      = (active_q == 4'b0000);

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Scoreboard bench for thread_fetch_sched: stimulus pushes expected fetches,
// a monitor pops and compares each fetch the DUT issues.
module tb_thread_fetch_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [8:0] pc_if;
    logic [1:0] thread_if;
    logic       fetch_valid;
    logic       redirect_valid;
    logic [1:0] redirect_thread;
    logic [8:0] redirect_pc;
    logic       done_valid;
    logic [1:0] done_thread;
    logic       restart;
    logic [3:0] thread_active;
    logic       all_done;

    typedef struct {
        logic [8:0] pc;
        logic [1:0] th;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic adv    = 1'b0;

    thread_fetch_sched dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .pc_if           (pc_if),
        .thread_if       (thread_if),
        .fetch_valid     (fetch_valid),
        .redirect_valid  (redirect_valid),
        .redirect_thread (redirect_thread),
        .redirect_pc     (redirect_pc),
        .done_valid      (done_valid),
        .done_thread     (done_thread),
        .restart         (restart),
        .thread_active   (thread_active),
        .all_done        (all_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Remember whether this edge was an advancing edge.
    always @(posedge clk) adv = en;

    // Monitor: every fetch presented after an advancing edge must match the queue head.
    always @(negedge clk) begin
        if (reset && adv && fetch_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", int'(pc_if), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fetch_pc", int'(pc_if), int'(e.pc));
                chk("fetch_thread", int'(thread_if), int'(e.th));
            end
        end
    end

    task automatic push(input logic [8:0] pc, input logic [1:0] th);
        exp_t e;
        e.pc = pc;
        e.th = th;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic e, input logic dv, input logic [1:0] dt,
                        input logic rv, input logic [1:0] rt, input logic [8:0] rp,
                        input logic rs);
        en = e; done_valid = dv; done_thread = dt;
        redirect_valid = rv; redirect_thread = rt; redirect_pc = rp;
        restart = rs;
        @(negedge clk);
    endtask

    task automatic run(input logic [8:0] pc, input logic [1:0] th);
        push(pc, th);
        tick(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en = 1'b0; done_valid = 1'b0; done_thread = 2'd0;
        redirect_valid = 1'b0; redirect_thread = 2'd0; redirect_pc = 9'd0;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc_if", int'(pc_if), 0);
        chk("rst_thread_if", int'(thread_if), 0);
        chk("rst_fetch_valid", int'(fetch_valid), 0);
        chk("rst_active", int'(thread_active), 15);
        chk("rst_all_done", int'(all_done), 0);
        reset = 1'b1;

        // Plain round-robin.
        run(9'd0, 2'd0);
        run(9'd128, 2'd1);
        run(9'd256, 2'd2);
        run(9'd384, 2'd3);
        run(9'd1, 2'd0);
        run(9'd129, 2'd1);

        // Retire thread 1 while redirecting thread 2 as it issues pc 257.
        push(9'd257, 2'd2);
        tick(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 9'h050, 1'b0);
        chk("active_after_done1", int'(thread_active), 13);
        run(9'd385, 2'd3);
        run(9'd2, 2'd0);
        run(9'h050, 2'd2);
        run(9'd386, 2'd3);
        run(9'd3, 2'd0);
        run(9'h051, 2'd2);

        // Stall with a redirect of thread 0 in the first stall cycle.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 2'd0, (i == 0), 2'd0, 9'h1F0, 1'b0);
            chk("stall_pc_if", int'(pc_if), 'h051);
            chk("stall_thread_if", int'(thread_if), 2);
            chk("stall_fetch_valid", int'(fetch_valid), 1);
        end
        run(9'd387, 2'd3);
        run(9'h1F0, 2'd0);

        // Redirect thread 3 to the top of the PC space; it wraps to 0.
        push(9'h052, 2'd2);
        tick(1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 9'd511, 1'b0);
        run(9'd511, 2'd3);
        run(9'h1F1, 2'd0);
        run(9'h053, 2'd2);
        run(9'd0, 2'd3);

        // Retire the remaining threads one per cycle.
        push(9'h054, 2'd2);
        tick(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 9'd0, 1'b0);
        push(9'd1, 2'd3);
        tick(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 9'd0, 1'b0);
        tick(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 9'd0, 1'b0);
        chk("none_fetch_valid", int'(fetch_valid), 0);
        chk("none_all_done", int'(all_done), 1);
        chk("none_active", int'(thread_active), 0);
        chk("none_pc_if_hold", int'(pc_if), 1);
        chk("none_thread_if_hold", int'(thread_if), 3);
        tick(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 1'b0);
        chk("idle_fetch_valid", int'(fetch_valid), 0);
        chk("idle_pc_if_hold", int'(pc_if), 1);

        // Restart re-arms everything; sequence resumes at thread 0.
        tick(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 1'b1);
        chk("restart_active", int'(thread_active), 15);
        chk("restart_all_done", int'(all_done), 0);
        chk("restart_fetch_valid", int'(fetch_valid), 0);
        chk("restart_pc_if_hold", int'(pc_if), 1);
        run(9'd0, 2'd0);
        run(9'd128, 2'd1);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pc_if", int'(pc_if), 0);
        chk("async_rst_thread_if", int'(thread_if), 0);
        chk("async_rst_fetch_valid", int'(fetch_valid), 0);
        chk("async_rst_active", int'(thread_active), 15);
        chk("async_rst_all_done", int'(all_done), 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
